// File: rtl/pc_sequencer.sv
`default_nettype none
// pc_sequencer: program counter sequencer with run/halt control and a return-address stack.
// Optional macro PC_SEQ_BRANCH_COUNT_EN adds a saturating redirect counter output.
module pc_sequencer #(
  parameter int D           = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] start_address,
  input  logic         branch,
  input  logic         taken,
  input  logic [D-1:0] target,
  input  logic         call,
  input  logic         ret,
  input  logic         halt,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
`ifdef PC_SEQ_BRANCH_COUNT_EN
  output logic [15:0]  redirect_count,
`endif
  output logic         stack_err
);

  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           push;
  logic [D-1:0]   stack_q [STACK_DEPTH];

  logic [D-1:0]   pc_inc;
  logic [SPW-1:0] sp_dec;
  logic           stk_empty, stk_full;

  assign pc_inc    = pc_q + D'(1);
  assign sp_dec    = sp_q - SPW'(1);
  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SPW'(STACK_DEPTH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = start_address;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (start) pc_d = start_address;
        else       state_d = RUN;
      end
      RUN: begin
        if (start) begin
          pc_d    = start_address;
          sp_d    = '0;
          err_d   = 1'b0;
          state_d = LOAD;
        end else if (halt) begin
          state_d = DONE;
        end else if (ret) begin
          // ret outranks call when both strobes are present
          if (stk_empty) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            sp_d = sp_dec;
            pc_d = stack_q[sp_dec[AW-1:0]];
          end
        end else if (call) begin
          if (stk_full) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SPW'(1);
            pc_d = target;
          end
        end else if (branch && taken) begin
          pc_d = target;
        end else begin
          pc_d = pc_inc;
        end
      end
      DONE: begin
        if (start) begin
          pc_d    = start_address;
          sp_d    = '0;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Stack contents are don't-care after reset, so the storage has no reset.
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[AW-1:0]] <= pc_inc;
  end

  assign prog_ctr  = pc_q;
  assign running   = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign stack_err = err_q;

`ifdef PC_SEQ_BRANCH_COUNT_EN
  logic        redirect;
  logic [15:0] cnt_q;

  assign redirect = (state_q == RUN) && !start && !halt &&
                    ((ret && !stk_empty) ||
                     (!ret && call && !stk_full) ||
                     (!ret && !call && branch && taken));

  // Every state loads start_address on start, so start alone clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              cnt_q <= 16'd0;
    else if (start)                         cnt_q <= 16'd0;
    else if (redirect && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign redirect_count = cnt_q;
`endif

endmodule
`default_nettype wire
